booth_dot_accum: RTL and testbench
==================================

Name: booth_dot_accum

Overview:
- Downstream consumer of the 6x6 Booth multiplier's result: `m[10:0]` plus `ov`.
- Accepts a stream of products over a valid/ready handshake and accumulates exactly LEN of them into a dot-product sum.
- Presents the sum on a valid/ready output port.
- Registered stage; converts the combinational multiplier output into a sequenced MAC result.

Parameters:
- LEN, 8, number of products per dot product (2..255).
- ACC_W, 20, accumulator/result width in bits (12..32).
- CNT_W, 8, width of term counter; must satisfy 2^CNT_W > LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new dot product when IDLE.
- clear  in  1  synchronous abort; returns to IDLE and zeroes the accumulator.
- in_valid  in  1  product beat present.
- in_ready  out  1  stage accepts a product this cycle.
- prod_m  in  11  multiplier result bits [10:0].
- prod_ov  in  1  multiplier ov bit, used as product bit 11.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- acc_out  out  ACC_W  accumulated sum, two's complement.
- acc_sat  out  1  sticky: saturation occurred in the current dot product.
- busy  out  1  high in ACCUM or DONE.
- term_cnt  out  CNT_W  products accepted so far in the current dot product.

Behaviour:
- Reset, asynchronous on rst_n low, all registers cleared immediately:
  - state=IDLE.
  - in_ready=0, out_valid=0, acc_out=0, acc_sat=0, busy=0, term_cnt=0.
- Product interpretation:
  - P = {prod_ov, prod_m}, a 12-bit two's-complement value.
  - P is sign-extended to ACC_W before the add.
- FSM states IDLE, ACCUM, DONE:
  - IDLE: in_ready=0, out_valid=0.
    - start=1 -> ACCUM next cycle; acc_out<=0, term_cnt<=0, acc_sat<=0.
  - ACCUM: in_ready=1.
    - Beat accepted when in_valid&&in_ready.
    - Accepted beat: acc_out<=acc_out+P; term_cnt<=term_cnt+1.
    - Beat that makes term_cnt reach LEN -> DONE next cycle.
    - The beat's sum is visible the same cycle out_valid rises, i.e. one cycle after the last accepted beat.
  - DONE: out_valid=1, in_ready=0; acc_out and term_cnt held stable.
    - out_valid&&out_ready -> IDLE next cycle; acc_out keeps its last value until the next start.
- Latency: last accepted product to out_valid = 1 cycle.
- Throughput: one product per cycle in ACCUM.
- start while ACCUM or DONE: ignored.
- start and out_ready handshake in the same DONE cycle: go to IDLE only; start is not queued.
- clear: highest synchronous priority in every state.
  - Next state IDLE; acc_out=0, term_cnt=0, acc_sat=0.
  - clear and an accepted beat in the same cycle: the beat is dropped.
- in_valid in IDLE/DONE: no effect; the upstream must hold the beat.
- busy = (state != IDLE), registered.
- Overflow handling depends on SAT_EN (see Optional Feature).

Optional Feature:
- Macro: BOOTH_ACC_SAT_EN.
- Defined:
  - Each add is evaluated at ACC_W+1 bits.
  - Positive overflow -> acc_out = 2^(ACC_W-1)-1.
  - Negative overflow -> acc_out = -2^(ACC_W-1).
  - acc_sat set, sticky until the next start or clear.
  - Later adds continue from the clamped value.
- Undefined:
  - Adds wrap modulo 2^ACC_W.
  - acc_sat tied to 0.

Decomposition:
- Shared package booth_pkg:
  - PROD_W=12.
  - State enum {IDLE, ACCUM, DONE} as 2-bit localparams.
  - Saturation limit helper function, parameterised by width.
- One natural sub-module: booth_sat_add.
  - Combinational sign-extend + add + optional clamp.
  - Outputs sum and overflow flag.
  - Instantiated once by the FSM/register top.

Test Plan:
- LEN=4, ACC_W=16; start, then four beats P=12'd35 (5*7) back-to-back -> out_valid one cycle after the 4th beat, acc_out=140, term_cnt=4, acc_sat=0.
- LEN=4, ACC_W=16; beats 12'hFF1 (-15), 12'd35, 12'hFF1, 12'd10 -> acc_out=16'd15. in_valid toggling every other cycle changes only timing, not the sum.
- ACC_W=12, BOOTH_ACC_SAT_EN defined; four beats 12'd1000 -> acc_out=2047, acc_sat=1. Without the macro -> acc_out=12'hFA0 (4000 mod 4096), acc_sat=0.
- DONE with out_ready=0 for 5 cycles -> out_valid and acc_out stable, in_ready=0. Then out_ready=1 -> IDLE next cycle; a start in that handshake cycle is ignored.
- clear asserted after 2 of 4 beats, same cycle as a valid beat -> IDLE, acc_out=0, term_cnt=0, no out_valid.
- rst_n low mid-ACCUM, asynchronously between clock edges -> all outputs zero immediately. After release, a fresh start + 4x12'd1 -> acc_out=4.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: product width, FSM states,
// and the saturation limit helper used when BOOTH_ACC_SAT_EN is defined.
package booth_pkg;

    localparam int PROD_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Two's-complement extreme for a given width, returned in the low 'width' bits.
    function automatic logic [31:0] sat_limit(input int width, input logic neg);
        logic [31:0] lim;
        lim = (32'd1 << (width - 1)) - 32'd1;
        if (neg) begin
            lim = ~lim;
        end
        return lim;
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational sign-extend and add of one 12-bit product into the accumulator.
// With BOOTH_ACC_SAT_EN defined the sum clamps on overflow; otherwise it wraps.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] prod_ext;

    assign prod_ext = ACC_W'($signed(prod));

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [31:0] LIM_POS = sat_limit(ACC_W, 1'b0);
    localparam logic [31:0] LIM_NEG = sat_limit(ACC_W, 1'b1);

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        // Top two bits disagree only when the true sum left the ACC_W range.
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        if (!ovf) begin
            sum = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            sum = LIM_NEG[ACC_W-1:0];
        end else begin
            sum = LIM_POS[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        sum = acc + prod_ext;
        ovf = 1'b0;
    end
`endif

endmodule

// File: rtl/booth_dot_accum.sv
// Sequenced MAC stage: accumulates LEN Booth products per dot product and hands the
// sum out over valid/ready. Saturating adds are selected by BOOTH_ACC_SAT_EN.
module booth_dot_accum
    import booth_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      prod_m,
    input  logic             prod_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_sat,
    output logic             busy,
    output logic [CNT_W-1:0] term_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sat_reg, sat_next;
    logic             busy_reg;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc_reg),
        .prod ({prod_ov, prod_m}),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sat_next   = sat_reg;
        // clear outranks every state, so a beat arriving with it is dropped.
        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        sat_next   = 1'b0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_next = add_sum;
                        cnt_next = cnt_reg + 1'b1;
                        sat_next = sat_reg | add_ovf;
                        if (cnt_reg == LAST_CNT) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign acc_out   = acc_reg;
    assign acc_sat   = sat_reg;
    assign busy      = busy_reg;
    assign term_cnt  = cnt_reg;

endmodule

// File: tb/tb_booth_dot_accum.sv
// Scoreboard bench for booth_dot_accum: two instances (ACC_W=16 and ACC_W=12, LEN=4)
// driven in lockstep; expectations follow BOOTH_ACC_SAT_EN when it is defined.
module tb_booth_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] prod_m = '0;
    logic        prod_ov = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready16, out_valid16, acc_sat16, busy16;
    logic [15:0] acc_out16;
    logic [7:0]  term_cnt16;
    logic        in_ready12, out_valid12, acc_sat12, busy12;
    logic [11:0] acc_out12;
    logic [7:0]  term_cnt12;

    typedef struct {
        logic [31:0] acc16;
        logic [31:0] acc12;
        logic        sat16;
        logic        sat12;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    booth_dot_accum #(.LEN(4), .ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready16), .prod_m(prod_m), .prod_ov(prod_ov),
        .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16),
        .acc_sat(acc_sat16), .busy(busy16), .term_cnt(term_cnt16)
    );

    booth_dot_accum #(.LEN(4), .ACC_W(12), .CNT_W(8)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready12), .prod_m(prod_m), .prod_ov(prod_ov),
        .out_valid(out_valid12), .out_ready(out_ready), .acc_out(acc_out12),
        .acc_sat(acc_sat12), .busy(busy12), .term_cnt(term_cnt12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference add: saturating or wrapping at width w.
    function automatic longint mdl_add(input longint acc, input logic [11:0] p,
                                       input int w, inout bit sat);
        longint s, hi, lo, pv;
        pv = longint'($signed(p));
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        s  = acc + pv;
`ifdef BOOTH_ACC_SAT_EN
        if (s > hi) begin
            s = hi; sat = 1'b1;
        end else if (s < lo) begin
            s = lo; sat = 1'b1;
        end
`else
        s = s & ((64'sd1 <<< w) - 1);
        if (s > hi) s = s - (64'sd1 <<< w);
`endif
        return s;
    endfunction

    task automatic drive_beat(input logic [11:0] p);
        in_valid = 1'b1;
        prod_m   = p[10:0];
        prod_ov  = p[11];
    endtask

    task automatic run_dot(input logic [11:0] b0, b1, b2, b3, input bit gap);
        logic [11:0] b[4];
        longint m16, m12;
        bit s16, s12;
        exp_t e;
        b = '{b0, b1, b2, b3};
        m16 = 0; m12 = 0; s16 = 0; s12 = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("accum_in_ready", 32'(in_ready16), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            check("term_cnt_progress", 32'(term_cnt16), 32'(i));
            drive_beat(b[i]);
            m16 = mdl_add(m16, b[i], 16, s16);
            m12 = mdl_add(m12, b[i], 12, s12);
            if (i == 3) begin
                e.acc16 = 32'(m16) & 32'hFFFF;
                e.acc12 = 32'(m12) & 32'hFFF;
                e.sat16 = s16;
                e.sat12 = s12;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        // Keep a junk beat offered: DONE must ignore it.
        drive_beat(12'h7FF);
        check("latency_out_valid", 32'(out_valid16), 32'd1);
    endtask

    task automatic collect(input int stall, input bit start_in_hs);
        exp_t e;
        logic [15:0] held;
        int k = 0;
        while (!out_valid16 && k < 8) begin
            @(negedge clk); k++;
        end
        if (!out_valid16) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        held = acc_out16;
        for (int i = 0; i < stall; i++) begin
            check("stall_out_valid", 32'(out_valid16), 32'd1);
            check("stall_in_ready", 32'({in_ready16, in_ready12}), 32'd0);
            check("stall_acc_stable", 32'(acc_out16), 32'(held));
            @(negedge clk);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        $display("result acc16=0x%0h acc12=0x%0h sat12=%0d (want 0x%0h 0x%0h %0d)",
                 acc_out16, acc_out12, acc_sat12, e.acc16, e.acc12, e.sat12);
        check("acc16", 32'(acc_out16), e.acc16);
        check("acc12", 32'(acc_out12), e.acc12);
        check("sat16", 32'(acc_sat16), 32'(e.sat16));
        check("sat12", 32'(acc_sat12), 32'(e.sat12));
        check("term_cnt_done", 32'(term_cnt12), 32'd4);
        check("out_valid12", 32'(out_valid12), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = start_in_hs;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_after_hs", 32'({busy16, busy12, out_valid16}), 32'd0);
        check("acc_held_idle", 32'(acc_out16), e.acc16);
        @(negedge clk);
        check("start_in_hs_ignored", 32'({busy16, in_ready16}), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({in_ready16, out_valid16, acc_sat16, busy16}), 32'd0);
        check("rst_acc", 32'(acc_out16), 32'd0);
        check("rst_cnt", 32'(term_cnt16), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_dot(12'd35, 12'd35, 12'd35, 12'd35, 1'b0);
        collect(0, 1'b0);
        run_dot(12'hFF1, 12'd35, 12'hFF1, 12'd10, 1'b1);
        collect(5, 1'b1);
        run_dot(12'd1000, 12'd1000, 12'd1000, 12'd1000, 1'b0);
        collect(1, 1'b0);
        run_dot(12'h800, 12'h800, 12'h800, 12'h800, 1'b1);
        collect(0, 1'b0);

        // clear lands on the same cycle as the third beat
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive_beat(12'd3); @(negedge clk);
        drive_beat(12'd4); @(negedge clk);
        drive_beat(12'd5); clear = 1'b1; @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("clear_state", 32'({busy16, in_ready16, out_valid16}), 32'd0);
        check("clear_acc", 32'(acc_out16), 32'd0);
        check("clear_cnt", 32'(term_cnt16), 32'd0);
        repeat (3) @(negedge clk);
        check("clear_no_out_valid", 32'(out_valid16), 32'd0);

        // asynchronous reset between edges mid-accumulation
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive_beat(12'd9); @(negedge clk);
        drive_beat(12'd9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_flags", 32'({in_ready16, out_valid16, acc_sat16, busy16}), 32'd0);
        check("async_rst_acc", 32'(acc_out16), 32'd0);
        check("async_rst_cnt", 32'(term_cnt16), 32'd0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_dot(12'd1, 12'd1, 12'd1, 12'd1, 1'b0);
        collect(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
